// File: rtl/snitch_icache_pkg.sv
// Shared icache types: per-port L0 and shared L1 event vectors, perf counter index map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package snitch_icache_pkg;

  typedef struct packed {
    logic l0_miss;
    logic l0_hit;
    logic l0_prefetch;
    logic l0_double_hit;
    logic l0_stall;
  } icache_l0_events_t;

  typedef struct packed {
    logic l1_miss;
    logic l1_hit;
    logic l1_stall;
    logic l1_handler_stall;
  } icache_l1_events_t;

  localparam int unsigned NUM_PERF_COUNTERS = 9;
  localparam int unsigned PERF_ADDR_W       = 4;

  typedef enum logic [PERF_ADDR_W-1:0] {
    PERF_L0_MISS          = 4'd0,
    PERF_L0_HIT           = 4'd1,
    PERF_L0_PREFETCH      = 4'd2,
    PERF_L0_DOUBLE_HIT    = 4'd3,
    PERF_L0_STALL         = 4'd4,
    PERF_L1_MISS          = 4'd5,
    PERF_L1_HIT           = 4'd6,
    PERF_L1_STALL         = 4'd7,
    PERF_L1_HANDLER_STALL = 4'd8,
    PERF_OVERFLOW         = 4'd9
  } icache_perf_idx_e;

  // Indices above the overflow register are unmapped and answer with an error.
  function automatic logic perf_addr_valid(input logic [PERF_ADDR_W-1:0] addr);
    return addr <= PERF_OVERFLOW;
  endfunction

endpackage

// File: rtl/snitch_icache_event_counter.sv
// Single perf counter: adds a small increment each cycle, wraps or clamps, loadable.
// Latency: increment/load visible on value_o one cycle later; overflow_o is same-cycle combinational.
// Backpressure: none, accepts an increment every cycle; a load discards that cycle's increment.
module snitch_icache_event_counter #(
  parameter int unsigned CNT_WIDTH = 32,
  parameter int unsigned INC_WIDTH = 1,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [INC_WIDTH-1:0] inc_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_value_i,
  output logic [CNT_WIDTH-1:0] value_o,
  output logic                 overflow_o
);

  logic [CNT_WIDTH-1:0] r_value;
  logic [CNT_WIDTH:0]   w_sum;
  logic [CNT_WIDTH-1:0] w_next;

  // One extra bit catches the carry-out; clamp replaces the wrapped sum when saturating.
  always_comb begin
    w_sum      = (CNT_WIDTH+1)'(r_value) + (CNT_WIDTH+1)'(inc_i);
    w_next     = (SATURATE && w_sum[CNT_WIDTH]) ? '1 : w_sum[CNT_WIDTH-1:0];
    overflow_o = w_sum[CNT_WIDTH] & ~load_i;
  end

  // Load wins over the increment arriving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_value <= '0;
    end else if (load_i) begin
      r_value <= load_value_i;
    end else begin
      r_value <= w_next;
    end
  end

  assign value_o = r_value;

endmodule

// File: rtl/snitch_icache_perf_counters.sv
// Icache perf counter bank: registers L0/L1 events, accumulates them, serves a register port.
// Latency: event visible 2 cycles after it is presented; register response 1 cycle after accept.
// Backpressure: one outstanding response; req_ready_o drops while a response waits on rsp_ready_i.
module snitch_icache_perf_counters
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_FETCH_PORTS = 2,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter bit          SATURATE       = 1'b0
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    enable_i,
  input  icache_l0_events_t [NR_FETCH_PORTS-1:0]  l0_events_i,
  input  icache_l1_events_t                       l1_events_i,
  input  logic                                    req_valid_i,
  output logic                                    req_ready_o,
  input  logic [PERF_ADDR_W-1:0]                  req_addr_i,
  input  logic                                    req_write_i,
  input  logic [CNT_WIDTH-1:0]                    req_wdata_i,
  output logic                                    rsp_valid_o,
  input  logic                                    rsp_ready_i,
  output logic [CNT_WIDTH-1:0]                    rsp_data_o,
  output logic                                    rsp_error_o
);

  localparam int unsigned INC_W   = $clog2(NR_FETCH_PORTS + 1);
  localparam int unsigned NUM     = NUM_PERF_COUNTERS;
  // Overflow bits that fit into one register word.
  localparam int unsigned OVF_VIS = (NUM < CNT_WIDTH) ? NUM : CNT_WIDTH;

  logic [4:0][INC_W-1:0]         w_l0_cnt;
  logic [4:0][INC_W-1:0]         r_l0_inc;
  logic [3:0]                    r_l1_inc;
  logic                          r_en;
  logic [NUM-1:0][INC_W-1:0]     w_inc;
  logic [NUM-1:0][CNT_WIDTH-1:0] w_value;
  logic [NUM-1:0]                w_ovf_pulse;
  logic [NUM-1:0]                w_load;
  logic [NUM-1:0]                w_ovf_w1c;
  logic [NUM-1:0]                r_ovf;
  logic [CNT_WIDTH-1:0]          w_rdata;
  logic                          w_accept;
  logic                          r_rsp_valid;
  logic [CNT_WIDTH-1:0]          r_rsp_data;
  logic                          r_rsp_error;

  // Popcount each L0 event field across all fetch ports.
  always_comb begin
    w_l0_cnt = '0;
    for (int p = 0; p < NR_FETCH_PORTS; p++) begin
      w_l0_cnt[0] = w_l0_cnt[0] + INC_W'(l0_events_i[p].l0_miss);
      w_l0_cnt[1] = w_l0_cnt[1] + INC_W'(l0_events_i[p].l0_hit);
      w_l0_cnt[2] = w_l0_cnt[2] + INC_W'(l0_events_i[p].l0_prefetch);
      w_l0_cnt[3] = w_l0_cnt[3] + INC_W'(l0_events_i[p].l0_double_hit);
      w_l0_cnt[4] = w_l0_cnt[4] + INC_W'(l0_events_i[p].l0_stall);
    end
  end

  // Stage 1: capture increments and the enable that belongs to them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_l0_inc <= '0;
      r_l1_inc <= '0;
      r_en     <= 1'b0;
    end else begin
      r_l0_inc <= w_l0_cnt;
      r_l1_inc <= {l1_events_i.l1_handler_stall, l1_events_i.l1_stall,
                   l1_events_i.l1_hit, l1_events_i.l1_miss};
      r_en     <= enable_i;
    end
  end

  // Stage 2 increments in index order, zeroed when counting was disabled.
  always_comb begin
    w_inc = '0;
    if (r_en) begin
      for (int i = 0; i < 5; i++) begin
        w_inc[i] = r_l0_inc[i];
      end
      for (int j = 0; j < 4; j++) begin
        w_inc[5+j] = INC_W'(r_l1_inc[j]);
      end
    end
  end

  assign req_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;

  // Decode writes: counter loads and W1C mask for the overflow register.
  always_comb begin
    w_load    = '0;
    w_ovf_w1c = '0;
    if (w_accept && req_write_i) begin
      for (int i = 0; i < NUM; i++) begin
        w_load[i] = (req_addr_i == PERF_ADDR_W'(i));
      end
      if (req_addr_i == PERF_OVERFLOW) begin
        for (int i = 0; i < OVF_VIS; i++) begin
          w_ovf_w1c[i] = req_wdata_i[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : gen_cnt
    snitch_icache_event_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .INC_WIDTH (INC_W),
      .SATURATE  (SATURATE)
    ) i_cnt (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .inc_i        (w_inc[g]),
      .load_i       (w_load[g]),
      .load_value_i (req_wdata_i),
      .value_o      (w_value[g]),
      .overflow_o   (w_ovf_pulse[g])
    );
  end

  // Sticky overflow: a fresh overflow beats a W1C clear; a counter load clears its bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= ((r_ovf & ~w_ovf_w1c) | w_ovf_pulse) & ~w_load;
    end
  end

  // Read mux on pre-update state; unmapped indices read as zero.
  always_comb begin
    w_rdata = '0;
    if (req_addr_i == PERF_OVERFLOW) begin
      for (int i = 0; i < OVF_VIS; i++) begin
        w_rdata[i] = r_ovf[i];
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (req_addr_i == PERF_ADDR_W'(i)) begin
          w_rdata = w_value[i];
        end
      end
    end
  end

  // Response register: loads on accept, holds until consumed, dropped by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= req_write_i ? '0 : w_rdata;
      r_rsp_error <= !perf_addr_valid(req_addr_i);
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_error_o = r_rsp_error;

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// Bench for the icache perf counter bank: wrapping and saturating instances share stimulus.
// Latency: responses scoreboarded in request order.
// Backpressure: rsp_ready driven by the bench to exercise stalls.
module tb_snitch_icache_perf_counters;
  import snitch_icache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    enable;
  icache_l0_events_t [1:0] l0_ev;
  icache_l1_events_t       l1_ev;
  logic                    req_valid;
  logic [3:0]              req_addr;
  logic                    req_write;
  logic [31:0]             req_wdata;
  logic                    rsp_ready;

  logic        req_ready_w, rsp_valid_w, rsp_err_w;
  logic [31:0] rsp_data_w;
  logic        req_ready_s, rsp_valid_s, rsp_err_s;
  logic [31:0] rsp_data_s;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] d_wrap;
    logic [31:0] d_sat;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  snitch_icache_perf_counters #(
    .NR_FETCH_PORTS (2),
    .CNT_WIDTH      (32),
    .SATURATE       (1'b0)
  ) u_dut_wrap (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .l0_events_i (l0_ev),
    .l1_events_i (l1_ev),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_w),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid_w),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data_w),
    .rsp_error_o (rsp_err_w)
  );

  snitch_icache_perf_counters #(
    .NR_FETCH_PORTS (2),
    .CNT_WIDTH      (32),
    .SATURATE       (1'b1)
  ) u_dut_sat (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .l0_events_i (l0_ev),
    .l1_events_i (l1_ev),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_s),
    .req_addr_i  (req_addr),
    .req_write_i (req_write),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid_s),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data_s),
    .rsp_error_o (rsp_err_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every completed response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid_w && rsp_ready) begin
      check("rsp_expected", 32'(sb.size() != 0), 32'd1);
      check("rsp_valid_match", 32'(rsp_valid_s), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_data_wrap"}, rsp_data_w, mon_e.d_wrap);
        check({mon_e.tag, "_data_sat"},  rsp_data_s, mon_e.d_sat);
        check({mon_e.tag, "_err_wrap"},  32'(rsp_err_w), 32'(mon_e.err));
        check({mon_e.tag, "_err_sat"},   32'(rsp_err_s), 32'(mon_e.err));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one request (called just after a posedge), returns one step after its accept edge.
  task automatic do_req(input string tag, input logic [3:0] a, input logic w,
                        input logic [31:0] d, input logic [31:0] e_wrap,
                        input logic [31:0] e_sat);
    exp_t e;
    int   n;
    e.tag    = tag;
    e.d_wrap = e_wrap;
    e.d_sat  = e_sat;
    e.err    = (a > 4'd9);
    sb.push_back(e);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    req_wdata = d;
    n = 0;
    @(negedge clk);
    while (!req_ready_w && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_accept"}, 32'(req_ready_w), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [31:0] e_wrap, input logic [31:0] e_sat);
    do_req(tag, a, 1'b0, 32'h0, e_wrap, e_sat);
  endtask

  task automatic wr(input string tag, input logic [3:0] a, input logic [31:0] d);
    do_req(tag, a, 1'b1, d, 32'h0, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    l0_ev     = '0;
    l1_ev     = '0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready",  32'(req_ready_w), 32'd1);
    check("rst_rsp_valid",  32'(rsp_valid_w), 32'd0);
    check("rst_rsp_data",   rsp_data_w,       32'd0);
    check("rst_sat_valid",  32'(rsp_valid_s), 32'd0);
    @(posedge clk);
    #1;

    // Everything reads zero after reset; index 12 is unmapped.
    for (int i = 0; i < 10; i++) begin
      rd($sformatf("rst_idx%0d", i), 4'(i), 32'h0, 32'h0);
    end
    rd("bad_idx12", 4'd12, 32'h0, 32'h0);

    // Both ports hit for 5 cycles -> +2 per cycle.
    l0_ev[0].l0_hit = 1'b1;
    l0_ev[1].l0_hit = 1'b1;
    cyc(5);
    l0_ev = '0;
    cyc(3);
    rd("hit_en",   4'd1, 32'd10, 32'd10);
    rd("miss_idle", 4'd0, 32'd0, 32'd0);

    // Same burst with counting disabled leaves the count alone.
    enable = 1'b0;
    l0_ev[0].l0_hit = 1'b1;
    l0_ev[1].l0_hit = 1'b1;
    cyc(5);
    l0_ev = '0;
    cyc(2);
    enable = 1'b1;
    cyc(1);
    rd("hit_dis", 4'd1, 32'd10, 32'd10);

    // Mixed pattern over 3 cycles.
    l0_ev[0].l0_miss     = 1'b1;
    l0_ev[0].l0_prefetch = 1'b1;
    l0_ev[1].l0_prefetch = 1'b1;
    l0_ev[1].l0_stall    = 1'b1;
    l1_ev.l1_stall       = 1'b1;
    cyc(3);
    l0_ev = '0;
    l1_ev = '0;
    cyc(3);
    rd("mix_miss",    4'd0, 32'd3, 32'd3);
    rd("mix_pref",    4'd2, 32'd6, 32'd6);
    rd("mix_dhit",    4'd3, 32'd0, 32'd0);
    rd("mix_stall",   4'd4, 32'd3, 32'd3);
    rd("mix_l1stall", 4'd7, 32'd3, 32'd3);
    rd("mix_handler", 4'd8, 32'd0, 32'd0);

    // Write to an unmapped index must not alias onto a counter.
    wr("wr_bad13", 4'd13, 32'hDEAD_BEEF);
    rd("alias5", 4'd5, 32'd0, 32'd0);

    // Preload near the top, then 3 L1 misses: wrap vs clamp.
    wr("wr5", 4'd5, 32'hFFFF_FFFE);
    l1_ev.l1_miss = 1'b1;
    cyc(3);
    l1_ev = '0;
    cyc(3);
    rd("ovf_cnt5", 4'd5, 32'h0000_0001, 32'hFFFF_FFFF);
    rd("ovf_reg",  4'd9, 32'h0000_0020, 32'h0000_0020);
    wr("w1c_ovf",  4'd9, 32'h0000_0020);
    cyc(3);
    rd("ovf_clr",  4'd9, 32'h0, 32'h0);
    rd("cnt5_hold", 4'd5, 32'h0000_0001, 32'hFFFF_FFFF);

    // Write lands on the same edge as a stage-2 increment: write wins.
    l1_ev.l1_hit = 1'b1;
    cyc(1);
    l1_ev = '0;
    wr("wr6", 4'd6, 32'h100);
    cyc(2);
    rd("wr_wins", 4'd6, 32'h100, 32'h100);
    l1_ev.l1_hit = 1'b1;
    cyc(1);
    l1_ev = '0;
    cyc(3);
    rd("wr_then_inc", 4'd6, 32'h101, 32'h101);

    // Response backpressure: hold rsp_ready low for 4 cycles with a queued request.
    cyc(2);
    rsp_ready = 1'b0;
    rd("bp_first", 4'd1, 32'd10, 32'd10);
    fork
      rd("bp_queued", 4'd4, 32'd3, 32'd3);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("bp_ready_low",   32'(req_ready_w), 32'd0);
          check("bp_valid_held",  32'(rsp_valid_w), 32'd1);
          check("bp_data_stable", rsp_data_w,       32'd10);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_release", 32'(req_ready_w), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_next_valid", 32'(rsp_valid_w), 32'd1);
        check("bp_next_data",  rsp_data_w,       32'd3);
      end
    join

    // Reset while a response is pending drops it.
    cyc(2);
    rsp_ready = 1'b0;
    rd("rst_dropped", 4'd1, 32'd10, 32'd10);
    @(negedge clk);
    check("pre_rst_valid", 32'(rsp_valid_w), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid",     32'(rsp_valid_w), 32'd0);
    check("rst_mid_sat_valid", 32'(rsp_valid_s), 32'd0);
    check("rst_mid_ready",     32'(req_ready_w), 32'd1);
    check("rst_mid_data",      rsp_data_w,       32'd0);
    sb.delete();
    rsp_ready = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    rd("post_rst_hit", 4'd1, 32'd0, 32'd0);
    rd("post_rst_l1m", 4'd5, 32'd0, 32'd0);
    rd("post_rst_ovf", 4'd9, 32'd0, 32'd0);
    cyc(3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snitch_icache_perf_counters.md
Name: snitch_icache_perf_counters

Overview:
- Consumer end of the icache event interface: receives the per-cycle icache_l0_events_t vectors from every L0 fetch port and the icache_l1_events_t struct from the shared L1.
- Accumulates each event into a software-visible counter bank.
- Bank is read, cleared and preloaded through a single-outstanding request/response register port.
- Sits beside the icache top level and feeds the cluster peripheral/CSR interconnect.

Parameters:
- NR_FETCH_PORTS, 2, number of L0 event inputs; must be ≥1.
- CNT_WIDTH, 32, width of each counter; must be ≥8.
- SATURATE, 1'b0, 1 = counters clamp at all-ones; 0 = counters wrap.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  global count enable, sampled with the events
- l0_events_i  in  NR_FETCH_PORTS x icache_l0_events_t  L0 events, one struct per port
- l1_events_i  in  icache_l1_events_t  L1 events
- req_valid_i  in  1  register request valid
- req_ready_o  out  1  register request ready
- req_addr_i  in  4  counter index 0..9
- req_write_i  in  1  1 = write, 0 = read
- req_wdata_i  in  CNT_WIDTH  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_data_o  out  CNT_WIDTH  read data (0 for writes)
- rsp_error_o  out  1  address out of range

Behaviour:
- Index map:
  - 0 l0_miss, 1 l0_hit, 2 l0_prefetch, 3 l0_double_hit, 4 l0_stall
  - 5 l1_miss, 6 l1_hit, 7 l1_stall, 8 l1_handler_stall
  - 9 overflow register, bit i = sticky overflow of counter i, upper bits 0
  - 10..15 invalid
- Stage 1 (cycle N):
  - All event inputs and enable_i registered.
  - L0 fields popcounted across ports; increment width is clog2(NR_FETCH_PORTS+1).
  - L1 increments are 0/1.
- Stage 2 (cycle N+1): counters add the registered increments when the registered enable is 1.
  - Event-to-visible latency: 2 cycles.
- Arithmetic, per counter:
  - SATURATE=0: sum taken modulo 2^CNT_WIDTH; carry-out sets the sticky overflow bit.
  - SATURATE=1: sum clamps to all-ones; overflow bit set when clamping occurs.
  - A counter already at all-ones receiving increment 0 stays put and does not set overflow.
- Handshake:
  - req_ready_o = !rsp_valid_o || rsp_ready_i.
  - Request accepted on req_valid_i && req_ready_o.
  - rsp_valid_o asserts the following cycle and holds, with rsp_data_o/rsp_error_o stable, until rsp_ready_i.
  - Back-to-back requests sustain 1 per cycle while rsp_ready_i=1.
- Read: returns the counter value at the accept edge, i.e. excluding that cycle's stage-2 increment.
- Write to index 0..8:
  - Loads req_wdata_i and clears that counter's overflow bit.
  - The stage-2 increment of that counter in the same cycle is discarded (write wins).
- Write to index 9: overflow bits cleared where req_wdata_i bit is 1 (W1C); simultaneous new overflow wins over clear.
- Invalid index:
  - rsp_error_o=1, rsp_data_o=0.
  - Writes have no effect.
- Reset, applied any cycle including mid-transaction:
  - All counters, overflow bits, stage-1 registers and rsp_valid_o/rsp_data_o/rsp_error_o go to 0 on the next edge.
  - req_ready_o=1 after reset.
  - A pending response is dropped.

Decomposition:
- Shared package snitch_icache_pkg gains:
  - icache_perf_idx_e enum (the index map)
  - NUM_PERF_COUNTERS = 9
  - PERF_ADDR_W = 4
- Sub-module snitch_icache_event_counter, one per counter:
  - clk_i/rst_i, increment input, load/load value, saturate parameter
  - Outputs value and overflow pulse.
  - Instantiated 9 times by a generate loop.

Test Plan:
- Reset, then read all 10 indices -> every rsp_data_o=0, rsp_error_o=0; read index 12 -> rsp_error_o=1, rsp_data_o=0.
- NR_FETCH_PORTS=2, both ports l0_hit=1 for 5 cycles, enable_i=1 -> index 1 reads 10 (read issued ≥2 cycles after last event); enable_i=0 during identical burst -> unchanged.
- SATURATE=0: write index 5 = 0xFFFFFFFE, then 3 l1_miss pulses -> reads 0x00000001, index 9 bit 5 = 1; write index 9 with 0x20 -> bit 5 cleared.
- SATURATE=1: same stimulus -> index 5 reads 0xFFFFFFFF, overflow bit 5 = 1.
- Write index 6 = 0x100 in the same cycle stage 2 would add an l1_hit -> reads 0x100; an l1_hit one cycle later -> 0x101.
- Hold rsp_ready_i=0 for 4 cycles after a read -> req_ready_o=0, rsp_data_o stable; release -> next queued request accepted the same cycle, response the next cycle; assert rst_i with rsp_valid_o=1 -> rsp_valid_o=0 the next cycle.
